pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, address width; RESET_VECTOR, default 0, PC value after reset; STEP, default 4, sequential increment; RAS_DEPTH, default 4, return-address-stack entries (power of 2, at least 2).
REQ-002 Ports SHALL be (name  direction  width  meaning):
- Clk  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- PCWrite  in  1  1 = PC may advance; 0 = stall, all state holds.
- BranchTaken  in  1  redirect to BranchTarget.
- BranchTarget  in  WIDTH  branch destination.
- Jump  in  1  redirect to JumpTarget.
- JumpTarget  in  WIDTH  jump destination.
- Call  in  1  redirect to JumpTarget and push PCResult+STEP.
- Return  in  1  redirect to popped RAS top.
- PCResult  out  WIDTH  current fetch address (registered).
- PCPlusStep  out  WIDTH  PCResult+STEP (combinational).
- Debug  out  WIDTH  PCResult value before the most recent update (registered).
- RasEmpty  out  1  RAS holds no entries.
- RasFull  out  1  RAS holds RAS_DEPTH entries.
- RasUnderflow  out  1  sticky: a Return was accepted while the RAS was empty.

Function
REQ-003 All updates SHALL occur on the rising Clk edge; PCResult SHALL change exactly one cycle after an accepted request (latency 1).
REQ-004 Requests are accepted only when PCWrite=1 and Reset=0. When PCWrite=0, PCResult, Debug, the RAS, and all flags SHALL hold, and request inputs SHALL be ignored.
REQ-005 Next-PC priority when accepted SHALL be: Return > Call > Jump > BranchTaken > sequential (PCResult+STEP).
REQ-006 Arithmetic SHALL be modulo 2^WIDTH: PCResult+STEP wraps to low bits without error indication.
REQ-007 Targets SHALL be used unmodified (no alignment masking).
REQ-008 Call SHALL set the next PC to JumpTarget and push PCResult+STEP. If the RAS is full, the push SHALL overwrite the oldest entry (circular), the count SHALL stay RAS_DEPTH, and RasFull SHALL remain 1.
REQ-009 Return with RAS non-empty SHALL set the next PC to the top entry and pop it.
REQ-010 Return with RAS empty SHALL hold PCResult, leave the RAS unchanged, and set RasUnderflow=1; RasUnderflow SHALL clear only on Reset.
REQ-011 Call and Return accepted together SHALL set the next PC to the popped top and replace that top with PCResult+STEP; the count is unchanged. If the RAS is empty, the push SHALL occur, the PC SHALL hold, and RasUnderflow SHALL be set.
REQ-012 Debug SHALL load the old PCResult on every accepted cycle, including a held PC under REQ-010.
REQ-013 RasEmpty and RasFull SHALL be registered-state decodes of the entry count (0 to RAS_DEPTH) and valid in the same cycle as the count.

Reset
REQ-014 When Reset=1 at a rising edge, regardless of other inputs, the block SHALL set: PCResult=RESET_VECTOR, Debug=0, RAS count=0 (RasEmpty=1, RasFull=0), RasUnderflow=0. RAS entry contents are don't-care.
REQ-015 Reset asserted mid-stall or mid-call-sequence SHALL take effect on that edge; the first accepted request after Reset deasserts SHALL advance from RESET_VECTOR.
REQ-016 The simulation initial value of PCResult SHALL equal RESET_VECTOR.

Structure
REQ-017 The shared package SHALL hold the default WIDTH, STEP, and RESET_VECTOR constants and a next-PC-source enum (SEQ, BRANCH, JUMP, CALL, RET).
REQ-018 The RAS SHALL be a sub-module, pc_ras (circular buffer with top pointer and count, push/pop/replace), instantiated once.
REQ-019 Next-PC selection SHALL be combinational logic in pc_unit, feeding a single PCResult register.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then 3 accepted cycles with no requests: PCResult = 0, 4, 8, 12; Debug = 0, 0, 4, 8.
- PCWrite=0 for 2 cycles with BranchTaken=1 at PC=0x10: PCResult stays 0x10. PCWrite=1 with BranchTarget=0x40: PCResult=0x40 next cycle.
- Call at PC=0x20 with JumpTarget=0x100, then Return at 0x104: PCResult = 0x100, then 0x24; RasEmpty goes 1 -> 0 -> 1.
- 5 Calls with RAS_DEPTH=4: RasFull=1. 4 Returns pop the last 4 return addresses in LIFO order; RasEmpty=1. A 5th Return holds the PC and sets RasUnderflow=1.
- WIDTH=32, PC=0xFFFFFFFC, sequential step: PCResult=0x00000000.
- Return, Call, and BranchTaken asserted together with top=0x80: PCResult=0x80 and the top becomes old PC+4. Reset asserted on the next edge gives PCResult=RESET_VECTOR and RasUnderflow=0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared defaults and next-PC source encoding for the PC unit.
package pc_unit_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int STEP_DEF = 4;
  localparam int unsigned RESET_VECTOR_DEF = 0;
  localparam int RAS_DEPTH_DEF = 4;
  typedef enum logic [2:0] {SEQ, BRANCH, JUMP, CALL, RET} pc_src_e;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a full push overwrites the oldest entry.
module pc_ras import pc_unit_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = RAS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  assign top = mem_q[ptr_q];
  assign empty = cnt_q == '0;
  assign full = cnt_q == CW'(DEPTH);
  // push with pop replaces the top in place; the caller never pops an empty stack
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (push && pop) begin
      mem_d[ptr_q] = wdata;
    end else if (push) begin
      ptr_d = ptr_q + 1'b1;
      mem_d[ptr_d] = wdata;
      cnt_d = full ? cnt_q : cnt_q + 1'b1;
    end else if (pop) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump/call/return redirection and a return-address stack.
module pc_unit import pc_unit_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
  parameter int STEP = STEP_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             PCWrite,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Call,
  input  logic             Return,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCPlusStep,
  output logic [WIDTH-1:0] Debug,
  output logic             RasEmpty,
  output logic             RasFull,
  output logic             RasUnderflow
);
  logic [WIDTH-1:0] pc_q = RESET_VECTOR;
  logic [WIDTH-1:0] pc_d, debug_q, debug_d, ras_top;
  logic uf_q, uf_d;
  pc_src_e src;
  assign PCResult = pc_q;
  assign PCPlusStep = pc_q + WIDTH'(STEP);
  assign Debug = debug_q;
  assign RasUnderflow = uf_q;
  // a Return on an empty stack holds the PC even when Call is also pushing
  always_comb begin
    src = Return ? RET : Call ? CALL : Jump ? JUMP : BranchTaken ? BRANCH : SEQ;
    pc_d = !PCWrite ? pc_q :
           src == RET ? (RasEmpty ? pc_q : ras_top) :
           (src == CALL || src == JUMP) ? JumpTarget :
           src == BRANCH ? BranchTarget : PCPlusStep;
    debug_d = PCWrite ? pc_q : debug_q;
    uf_d = uf_q | (PCWrite & Return & RasEmpty);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q <= RESET_VECTOR;
      debug_q <= '0;
      uf_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      debug_q <= debug_d;
      uf_q <= uf_d;
    end
  end
  pc_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(Clk),
    .rst(Reset),
    .push(PCWrite & Call),
    .pop(PCWrite & Return & ~RasEmpty),
    .wdata(PCPlusStep),
    .top(ras_top),
    .empty(RasEmpty),
    .full(RasFull)
  );
endmodule
